// File: rtl/mips_regfile_p.sv
`default_nettype none
// ============================================================================
// Module      : mips_regfile_p
// Description : MIPS general-purpose register file with HI/LO pair.
//               Two combinational read ports, one synchronous write port,
//               register 0 reads as zero, and a sequential clear engine
//               that wipes r1..r(DEPTH-1) after reset or on request.
//               Optional feature macro: REGFILE_BYPASS_EN (write-to-read
//               forwarding on both GPR ports and on HI/LO).
// Revision    : 1.0 - initial release
// ============================================================================
module mips_regfile_p #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wren,
    input  logic [ADDR_W-1:0] wr,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    output logic [DATA_W-1:0] rs,
    output logic [DATA_W-1:0] rt,
    input  logic              hilo_wren,
    input  logic [DATA_W-1:0] hi_wd,
    input  logic [DATA_W-1:0] lo_wd,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    input  logic              clr_req,
    output logic              busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_cnt_first = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_cnt_last  = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    // Register 0 is never stored; it is decoded as zero on the read side.
    logic [DATA_W-1:0] r_mem [1:DEPTH-1];

    logic w_busy;
    logic w_gpr_we;
    logic w_hilo_we;

    assign w_busy    = (r_state == S_CLEAR);
    assign w_gpr_we  = wren && !w_busy && (wr != '0);
    assign w_hilo_we = hilo_wren && !w_busy;
    assign busy      = w_busy;

    // Clear engine: walks the counter from 1 to DEPTH-1, one entry per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= c_cnt_first;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_state <= S_CLEAR;
                        r_cnt   <= c_cnt_first;
                    end
                end
                S_CLEAR: begin
                    // clr_req is deliberately ignored here: no restart.
                    if (r_cnt == c_cnt_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= c_cnt_first;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_first;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_cnt   <= c_cnt_first;
                end
            endcase
        end
    end

    // HI/LO pair: cleared immediately by reset, loaded when not busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_hilo_we) begin
            r_hi <= hi_wd;
            r_lo <= lo_wd;
        end
    end

    // GPR array: the clear engine owns the write port while busy.
    always_ff @(posedge clk) begin
        if (w_busy) begin
            r_mem[r_cnt] <= '0;
        end else if (w_gpr_we) begin
            r_mem[wr] <= wd;
        end
    end

    // Read port 1: zero while busy or for r0, optional forwarding of wd.
    always_comb begin
        rs = '0;
        if (!w_busy && (rr1 != '0)) begin
            rs = r_mem[rr1];
`ifdef REGFILE_BYPASS_EN
            if (w_gpr_we && (wr == rr1)) begin
                rs = wd;
            end
`endif
        end
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        rt = '0;
        if (!w_busy && (rr2 != '0)) begin
            rt = r_mem[rr2];
`ifdef REGFILE_BYPASS_EN
            if (w_gpr_we && (wr == rr2)) begin
                rt = wd;
            end
`endif
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign hi = w_hilo_we ? hi_wd : r_hi;
    assign lo = w_hilo_we ? lo_wd : r_lo;
`else
    assign hi = r_hi;
    assign lo = r_lo;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_regfile_p
// Description : Directed self-checking bench for mips_regfile_p at default
//               parameters (32 x 32). Expectations follow REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_regfile_p;

    logic        clk;
    logic        rst;
    logic        wren;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        hilo_wren;
    logic [31:0] hi_wd;
    logic [31:0] lo_wd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        clr_req;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mips_regfile_p #(.DATA_W(32), .DEPTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .wren      (wren),
        .wr        (wr),
        .wd        (wd),
        .rr1       (rr1),
        .rr2       (rr2),
        .rs        (rs),
        .rt        (rt),
        .hilo_wren (hilo_wren),
        .hi_wd     (hi_wd),
        .lo_wd     (lo_wd),
        .hi        (hi),
        .lo        (lo),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy falls; also verifies reads stay zero meanwhile.
    task automatic count_busy(output int n, output bit reads_zero);
        n = 0;
        reads_zero = 1'b1;
        while (busy && n < 200) begin
            if (rs !== 32'h0 || rt !== 32'h0) reads_zero = 1'b0;
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int  n;
        bit  rz;
        rst = 1'b1; wren = 1'b0; wr = '0; wd = '0; rr1 = 5'd5; rr2 = 5'd31;
        hilo_wren = 1'b0; hi_wd = '0; lo_wd = '0; clr_req = 1'b0;
        #2;
        tick(); tick();
        checks++;
        if (busy !== 1'b1 || rs !== 32'h0 || rt !== 32'h0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rs=%h rt=%h hi=%h lo=%h, required busy=1 all zero",
                     busy, rs, rt, hi, lo);
        end
        rst = 1'b0;
        count_busy(n, rz);
        checks++;
        if (n !== 31) begin
            errors++;
            $display("FAIL reset_clear_len: busy edges=%0d, required 31", n);
        end
        checks++;
        if (!rz || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_clear_zero: reads_zero=%0d hi=%h lo=%h, required 1/0/0", rz, hi, lo);
        end
    endtask

    task automatic test_write();
        wren = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF;
        tick();
        wren = 1'b0; rr1 = 5'd5; rr2 = 5'd5;
        #1;
        checks++;
        if (rs !== 32'hDEADBEEF || rt !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_r5: rs=%h rt=%h, required deadbeef", rs, rt);
        end
        wren = 1'b1; wr = 5'd0; wd = 32'h1234;
        tick();
        wren = 1'b0; rr1 = 5'd0;
        #1;
        checks++;
        if (rs !== 32'h0) begin
            errors++;
            $display("FAIL write_r0: rs=%h, required 0", rs);
        end
    endtask

    task automatic test_hilo();
        wren = 1'b1; wr = 5'd3; wd = 32'hC;
        hilo_wren = 1'b1; hi_wd = 32'hA; lo_wd = 32'hB;
        tick();
        wren = 1'b0; hilo_wren = 1'b0; rr1 = 5'd3;
        #1;
        checks++;
        if (hi !== 32'hA || lo !== 32'hB || rs !== 32'hC) begin
            errors++;
            $display("FAIL hilo_same_edge: hi=%h lo=%h r3=%h, required a/b/c", hi, lo, rs);
        end
    endtask

    task automatic test_busy_block();
        int n;
        bit rz;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL pre_clear_busy: busy=%b, required 0", busy);
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clr_busy_next: busy=%b, required 1", busy);
        end
        // Attempt GPR and HI/LO writes during the clear; retrigger at edge 10.
        wren = 1'b1; wr = 5'd7; wd = 32'h77;
        hilo_wren = 1'b1; hi_wd = 32'h99; lo_wd = 32'h88;
        n = 0;
        while (busy && n < 200) begin
            clr_req = (n == 10);
            tick();
            n++;
        end
        clr_req = 1'b0; wren = 1'b0; hilo_wren = 1'b0;
        checks++;
        if (n !== 31) begin
            errors++;
            $display("FAIL clr_mid_req_len: busy edges=%0d, required 31", n);
        end
        rr1 = 5'd5; rr2 = 5'd7;
        #1;
        checks++;
        if (rt !== 32'h0 || rs !== 32'h0 || hi !== 32'hA || lo !== 32'hB) begin
            errors++;
            $display("FAIL busy_write_dropped: r5=%h r7=%h hi=%h lo=%h, required 0/0/a/b",
                     rs, rt, hi, lo);
        end
        count_busy(n, rz);
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL no_extra_clear: busy edges=%0d, required 0", n);
        end
    endtask

    task automatic test_fill_clear_reset();
        int n;
        bit rz;
        bit ok;
        for (int i = 1; i < 32; i++) begin
            wren = 1'b1; wr = 5'(i); wd = 32'h5A00_0000 | 32'(i);
            tick();
        end
        wren = 1'b0;
        ok = 1'b1;
        for (int i = 1; i < 32; i++) begin
            rr1 = 5'(i); rr2 = 5'(32 - i);
            #1;
            if (rs !== (32'h5A00_0000 | 32'(i)) || rt !== (32'h5A00_0000 | 32'(32 - i))) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fill_readback: last rs=%h rt=%h, required 5a0000xx pattern", rs, rt);
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_edge10_busy: busy=%b, required 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: hi=%h lo=%h busy=%b, required 0/0/1", hi, lo, busy);
        end
        tick(); tick();
        rst = 1'b0;
        count_busy(n, rz);
        checks++;
        if (n !== 31 || !rz) begin
            errors++;
            $display("FAIL reset_restart_len: busy edges=%0d reads_zero=%0d, required 31/1", n, rz);
        end
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rr1 = 5'(i); rr2 = 5'(31 - i);
            #1;
            if (rs !== 32'h0 || rt !== 32'h0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL all_cleared: last rs=%h rt=%h, required 0", rs, rt);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_rd;
        logic [31:0] exp_hi;
        wren = 1'b1; wr = 5'd9; wd = 32'h11;
        tick();
        wr = 5'd9; wd = 32'h55; rr1 = 5'd9; rr2 = 5'd9;
        hilo_wren = 1'b1; hi_wd = 32'h66; lo_wd = 32'h67;
`ifdef REGFILE_BYPASS_EN
        exp_rd = 32'h55;
        exp_hi = 32'h66;
`else
        exp_rd = 32'h11;
        exp_hi = 32'h0;
`endif
        #1;
        checks++;
        if (rs !== exp_rd || rt !== exp_rd) begin
            errors++;
            $display("FAIL bypass_same_cycle: rs=%h rt=%h, required %h", rs, rt, exp_rd);
        end
        checks++;
        if (hi !== exp_hi) begin
            errors++;
            $display("FAIL bypass_hi: hi=%h, required %h", hi, exp_hi);
        end
        tick();
        wren = 1'b0; hilo_wren = 1'b0;
        #1;
        checks++;
        if (rs !== 32'h55 || hi !== 32'h66 || lo !== 32'h67) begin
            errors++;
            $display("FAIL bypass_after_edge: rs=%h hi=%h lo=%h, required 55/66/67", rs, hi, lo);
        end
        wren = 1'b1; wr = 5'd0; wd = 32'hFF; rr1 = 5'd0;
        #1;
        checks++;
        if (rs !== 32'h0) begin
            errors++;
            $display("FAIL bypass_r0: rs=%h, required 0", rs);
        end
        tick();
        wren = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_hilo();
        test_busy_block();
        test_fill_clear_reset();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
